// File: rtl/tsc_pkg.sv
// Shared types and defaults for the traffic signal controller blocks.
package tsc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StWalk    = 2'd2,
    StLockout = 2'd3
  } ped_state_e;

  localparam int unsigned DefSyncStages     = 2;
  localparam int unsigned DefDebounceCycles = 20;
  localparam int unsigned DefWalkCycles     = 40;
  localparam int unsigned DefLockoutCycles  = 60;
  localparam int unsigned DefCntW           = 16;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ped_request_ctrl_if.sv
// Button/controller-side signal bundle for the pedestrian request front end.
interface ped_request_ctrl_if;
  logic       btn_raw;
  logic       yellow_in;
  logic       walk_req;
  logic       req_pending;
  logic       btn_clean;
  logic [7:0] req_count;

  modport master (
    output btn_raw, yellow_in,
    input  walk_req, req_pending, btn_clean, req_count
  );

  modport slave (
    input  btn_raw, yellow_in,
    output walk_req, req_pending, btn_clean, req_count
  );
endinterface

// File: rtl/btn_debounce.sv
// Button synchroniser and debouncer with a single-cycle rising-edge press pulse.
module btn_debounce
  import tsc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_clean,
  output logic press
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [CNT_W-1:0]       cnt_q;
  logic                   clean_q;
  logic                   clean_prev_q;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous button level through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
    end else begin
      clean_prev_q <= clean_q;
      if (btn_sync == clean_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        clean_q <= btn_sync;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign btn_clean = clean_q;
  assign press     = clean_q & ~clean_prev_q;

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian request front end: latches debounced presses and times walk/lockout windows.
module ped_request_ctrl
  import tsc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned WALK_CYCLES     = DefWalkCycles,
  parameter int unsigned LOCKOUT_CYCLES  = DefLockoutCycles,
  parameter int unsigned CNT_W           = DefCntW
) (
  input logic               clk,
  input logic               reset_n,
  ped_request_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] WalkLoad = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LockLoad = CNT_W'(LOCKOUT_CYCLES - 1);

  ped_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             flag_q, flag_d;
  logic [7:0]       count_q, count_d;
  logic             walk_q;
  logic             pend_q;
  logic             btn_clean;
  logic             press;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_raw  (bus.btn_raw),
    .btn_clean(btn_clean),
    .press    (press)
  );

  // Next-state, shared walk/lockout down-counter, pending flag and press count.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    flag_d  = flag_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (press) begin
          count_d = sat_inc8(count_q);
          if (!bus.yellow_in) begin
            state_d = StWalk;
            timer_d = WalkLoad;
          end else begin
            state_d = StPending;
          end
        end
      end
      StPending: begin
        if (!bus.yellow_in) begin
          state_d = StWalk;
          timer_d = WalkLoad;
        end
      end
      StWalk: begin
        if (timer_q == '0) begin
          state_d = StLockout;
          timer_d = LockLoad;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StLockout: begin
        if (press && !flag_q) begin
          flag_d  = 1'b1;
          count_d = sat_inc8(count_q);
        end
        // A press landing on the expiry cycle is folded in via flag_d.
        if (timer_q == '0) begin
          state_d = flag_d ? StPending : StIdle;
          flag_d  = 1'b0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, timers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      flag_q  <= 1'b0;
      count_q <= '0;
      walk_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      flag_q  <= flag_d;
      count_q <= count_d;
      walk_q  <= (state_d == StWalk);
      pend_q  <= (state_d == StPending) | flag_d;
    end
  end

  assign bus.walk_req    = walk_q;
  assign bus.req_pending = pend_q;
  assign bus.btn_clean   = btn_clean;
  assign bus.req_count   = count_q;

endmodule
